// File: rtl/regfile_pkg.sv
// Shared widths and write-back controller state type for the register file
// write-port logic.
package regfile_pkg;

  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned WR_CNT_W   = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } wb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: one-hot grant to the first request found
// searching upward from ptr with wrap-around, gated by en.
module rr_arbiter #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             en,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             grant_vld
);

  int unsigned idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      idx = 32'(ptr) + off;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (en && !grant_vld && req[idx[PTR_W-1:0]]) begin
        grant[idx[PTR_W-1:0]] = 1'b1;
        grant_idx             = idx[PTR_W-1:0];
        grant_vld             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port, with
// registered write outputs and same-cycle forwarding onto both read ports.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned N_REQ = 3
) (
  input  logic                          clk,
  input  logic                          ares,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [N_REQ*REG_DATA_W-1:0]   req_data,
  input  logic                          stall,
  output logic                          wen,
  output logic [ADDR_WIDTH-1:0]         waddr,
  output logic [REG_DATA_W-1:0]         wdata,
  input  logic [ADDR_WIDTH-1:0]         raddr1,
  input  logic [ADDR_WIDTH-1:0]         raddr2,
  input  logic [REG_DATA_W-1:0]         rf_rdata1,
  input  logic [REG_DATA_W-1:0]         rf_rdata2,
  output logic [REG_DATA_W-1:0]         rdata1,
  output logic [REG_DATA_W-1:0]         rdata2,
  output logic [$clog2(N_REQ)-1:0]      grant_id,
  output logic [WR_CNT_W-1:0]           wr_cnt
);

  localparam int unsigned PTR_W = $clog2(N_REQ);

  wb_state_t             state_q, state_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [REG_DATA_W-1:0] wdata_q, wdata_d;
  logic [PTR_W-1:0]      grant_id_q, grant_id_d;
  logic [WR_CNT_W-1:0]   wr_cnt_q, wr_cnt_d;

  logic [N_REQ-1:0]      grant;
  logic [PTR_W-1:0]      grant_idx;
  logic                  grant_vld;
  logic                  arb_en;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [REG_DATA_W-1:0] sel_data;
  logic                  xfer_wr;

  // Reset gates the grant combinationally so no handshake completes while ares is high.
  assign arb_en = !stall && !ares;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign req_ready = grant;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data[i*REG_DATA_W +: REG_DATA_W];
      end
    end
  end

  assign xfer_wr = grant_vld && (sel_addr != '0);

  always_comb begin
    state_d    = xfer_wr ? WRITE : IDLE;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    wr_cnt_d   = wr_cnt_q;
    if (grant_vld) begin
      grant_id_d = grant_idx;
      rr_ptr_d   = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
    end
    if (xfer_wr) begin
      waddr_d = sel_addr;
      wdata_d = sel_data;
      if (wr_cnt_q != '1) begin
        wr_cnt_d = wr_cnt_q + WR_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge ares) begin
    if (ares) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wr_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  assign wen      = (state_q == WRITE);
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign grant_id = grant_id_q;
  assign wr_cnt   = wr_cnt_q;

  // x0 never forwards: the file's hard-wired zero always wins for address 0.
  assign rdata1 = (wen && (raddr1 == waddr_q) && (raddr1 != '0)) ? wdata_q : rf_rdata1;
  assign rdata2 = (wen && (raddr2 == waddr_q) && (raddr2 != '0)) ? wdata_q : rf_rdata2;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized self-checking bench for regfile_wb_arbiter against a
// behavioural model of the arbitration, write registers and forwarding.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        ares = 1'b1;
  logic [2:0]  v_valid;
  logic [4:0]  a [3];
  logic [31:0] d [3];
  logic        stall;
  logic [4:0]  raddr1, raddr2;

  logic [2:0]  req_ready;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] rf_rdata1, rf_rdata2, rdata1, rdata2;
  logic [1:0]  grant_id;
  logic [15:0] wr_cnt;

  logic [31:0] rf [32];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.N_REQ(3)) dut (
    .clk       (clk),
    .ares      (ares),
    .req_valid (v_valid),
    .req_ready (req_ready),
    .req_addr  ({a[2], a[1], a[0]}),
    .req_data  ({d[2], d[1], d[0]}),
    .stall     (stall),
    .wen       (wen),
    .waddr     (waddr),
    .wdata     (wdata),
    .raddr1    (raddr1),
    .raddr2    (raddr2),
    .rf_rdata1 (rf_rdata1),
    .rf_rdata2 (rf_rdata2),
    .rdata1    (rdata1),
    .rdata2    (rdata2),
    .grant_id  (grant_id),
    .wr_cnt    (wr_cnt)
  );

  // Register file driven by the DUT write port; x0 reads as zero.
  initial for (int i = 0; i < 32; i++) rf[i] = '0;
  always @(posedge clk) if (wen && waddr != 0) rf[waddr] <= wdata;
  assign rf_rdata1 = (raddr1 == 0) ? 32'h0 : rf[raddr1];
  assign rf_rdata2 = (raddr2 == 0) ? 32'h0 : rf[raddr2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_ptr = 0, n_ptr = 0;
  logic        m_wen = 0, n_wen = 0;
  logic [4:0]  m_waddr = 0, n_waddr = 0;
  logic [31:0] m_wdata = 0, n_wdata = 0;
  int          m_gid = 0, n_gid = 0;
  int          m_cnt = 0, n_cnt = 0;
  logic [31:0] mrf [32];
  initial for (int i = 0; i < 32; i++) mrf[i] = '0;

  function automatic int model_winner(logic [2:0] v, int p, logic st, logic rs);
    if (st || rs) return -1;
    for (int k = 0; k < 3; k++) if (v[(p + k) % 3]) return (p + k) % 3;
    return -1;
  endfunction

  function automatic logic [31:0] model_read(logic [4:0] ra);
    if (ra == 0) return 32'h0;
    if (m_wen && ra == m_waddr) return m_wdata;
    return mrf[ra];
  endfunction

  always @(posedge clk or posedge ares) begin
    if (ares) begin
      m_ptr <= 0; m_wen <= 0; m_waddr <= 0; m_wdata <= 0; m_gid <= 0; m_cnt <= 0;
    end else begin
      m_ptr <= n_ptr; m_wen <= n_wen; m_waddr <= n_waddr; m_wdata <= n_wdata;
      m_gid <= n_gid; m_cnt <= n_cnt;
    end
  end

  always @(posedge clk) if (m_wen && m_waddr != 0) mrf[m_waddr] <= m_wdata;

  // Compare process: check every cycle at the falling edge, then form next state.
  always @(negedge clk) begin
    int w;
    logic [2:0] e_ready;
    w = model_winner(v_valid, m_ptr, stall, ares);
    e_ready = (w < 0) ? 3'b000 : (3'b001 << w);
    chk("req_ready", req_ready, e_ready);
    chk("wen", wen, m_wen);
    chk("waddr", waddr, m_waddr);
    chk("wdata", wdata, m_wdata);
    chk("grant_id", grant_id, m_gid);
    chk("wr_cnt", wr_cnt, m_cnt);
    chk("rdata1", rdata1, model_read(raddr1));
    chk("rdata2", rdata2, model_read(raddr2));
    n_ptr = m_ptr; n_wen = 0; n_waddr = m_waddr; n_wdata = m_wdata;
    n_gid = m_gid; n_cnt = m_cnt;
    if (w >= 0) begin
      n_ptr = (w + 1) % 3;
      n_gid = w;
      if (a[w] != 0) begin
        n_wen = 1; n_waddr = a[w]; n_wdata = d[w];
        n_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus with literal pins ----------------
  initial begin
    stall = 0; raddr1 = 0; raddr2 = 0;
    v_valid = 3'b111;
    a[0] = 5'd1; a[1] = 5'd2; a[2] = 5'd3;
    d[0] = 32'hAAAA_AAAA; d[1] = 32'hBBBB_BBBB; d[2] = 32'hCCCC_CCCC;

    @(posedge clk); #4;
    chk("rst_ready", req_ready, 3'b000);
    chk("rst_wen", wen, 1'b0);
    chk("rst_wr_cnt", wr_cnt, 16'd0);
    @(posedge clk); #1;
    ares = 0;

    for (int k = 0; k < 6; k++) begin
      #3;
      chk("fair_ready", req_ready, 3'b001 << (k % 3));
      chk("fair_wen", wen, (k != 0));
      step();
    end
    v_valid = 3'b000;
    #3;
    chk("fair_last_wen", wen, 1'b1);
    chk("fair_wr_cnt", wr_cnt, 16'd6);
    chk("fair_waddr", waddr, 5'd3);
    chk("fair_wdata", wdata, 32'hCCCC_CCCC);
    step();

    v_valid = 3'b010; a[1] = 5'd0; d[1] = 32'hDEAD_BEEF; raddr1 = 0;
    #3 chk("x0_ready", req_ready, 3'b010);
    step();
    v_valid = 3'b000;
    #3;
    chk("x0_wen", wen, 1'b0);
    chk("x0_wr_cnt", wr_cnt, 16'd6);
    chk("x0_rdata1", rdata1, 32'h0);
    step();

    v_valid = 3'b001; a[0] = 5'd5; d[0] = 32'h1234_5678; raddr1 = 5'd5;
    #3 chk("fwd_ready", req_ready, 3'b001);
    step();
    v_valid = 3'b000;
    #3;
    chk("fwd_wen", wen, 1'b1);
    chk("fwd_rdata1", rdata1, 32'h1234_5678);
    chk("fwd_rf_old", rf_rdata1, 32'h0);
    step();
    #3;
    chk("fwd_rf_new", rf_rdata1, 32'h1234_5678);
    chk("fwd_rdata1_file", rdata1, 32'h1234_5678);
    step();

    stall = 1; v_valid = 3'b010; a[1] = 5'd9; d[1] = 32'h0000_0099;
    repeat (3) begin
      #3;
      chk("stall_ready", req_ready, 3'b000);
      chk("stall_wen", wen, 1'b0);
      step();
    end
    stall = 0;
    #3 chk("unstall_ready", req_ready, 3'b010);
    step();
    v_valid = 3'b000;
    #3;
    chk("unstall_wen", wen, 1'b1);
    chk("unstall_waddr", waddr, 5'd9);
    step();

    v_valid = 3'b001; a[0] = 5'd7; d[0] = 32'h0000_0077; raddr2 = 5'd7;
    #3 chk("rstmid_ready", req_ready, 3'b001);
    @(negedge clk); #1;
    ares = 1; v_valid = 3'b000;
    @(posedge clk); #1;
    chk("rstmid_wen", wen, 1'b0);
    chk("rstmid_waddr", waddr, 5'd0);
    chk("rstmid_rdata2", rdata2, 32'h0);
    step();
    ares = 0;
    #3 chk("rstmid_no_pulse", wen, 1'b0);
    step();
    #3 chk("rstmid_file", rf_rdata2, 32'h0);
    step();

    for (int c = 0; c < 3000; c++) begin
      v_valid = 3'($urandom);
      for (int i = 0; i < 3; i++) begin
        a[i] = 5'($urandom % 8);
        d[i] = $urandom;
      end
      stall  = ($urandom % 4 == 0);
      raddr1 = 5'($urandom % 8);
      raddr2 = 5'($urandom % 8);
      ares   = ($urandom % 300 == 0);
      step();
    end
    ares = 0; v_valid = 3'b000; stall = 0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
